// File: rtl/md_sched_if.sv
// md_sched_if
// Bundles the EX-stage request side and the HI/LO result side of the
// multiply/divide scheduler so the pipeline and the scheduler share one port.
//
// Signals:
//   start  operation valid from EX this cycle
//   op     0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
//   req    CP0 exception/interrupt request, blocks acceptance this cycle
//   a, b   rs / rt operands
//   busy   multi-cycle operation in progress (registered)
//   stall  combinational E_Busy stall for the pipeline
//   done   one-cycle pulse after a mult/div commits to HI/LO
//   hi, lo architectural HI/LO registers
//
// Modports:
//   master  the pipeline side (drives the request, reads results)
//   slave   the scheduler side (reads the request, drives results)
interface md_sched_if;
    logic        start;
    logic [2:0]  op;
    logic        req;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, req, a, b,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, req, a, b,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/md_sched.sv
// md_sched
// MIPS-style HI/LO multiply/divide scheduler. The arithmetic result is
// computed at acceptance and parked in resHi/resLo; the block then models the
// unit latency by staying busy for MULT_CYCLES or DIV_CYCLES cycles before
// committing to the architectural HI/LO registers. mthi/mtlo write directly.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (1..15)
//   DIV_CYCLES   busy cycles for div/divu   (1..15)
//
// Ports:
//   clk    single clock, all state on the rising edge
//   reset  asynchronous, active-low reset
//   bus    md_sched_if.slave (start/op/req/a/b in, busy/stall/done/hi/lo out)
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_sched_if.slave  bus
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] resHi_q, resHi_d;
    logic [31:0] resLo_q, resLo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic        isMulDiv;
    logic        isDiv;
    logic        accept;
    logic        finish;
    logic [31:0] opHi;
    logic [31:0] opLo;
    logic [63:0] aSext, bSext, aZext, bZext;

    // Decode of the incoming request. Reserved op 7 and op 0 never qualify,
    // and a pending CP0 request blocks acceptance outright.
    assign isMulDiv = (bus.op >= 3'd1) && (bus.op <= 3'd4);
    assign isDiv    = (bus.op == 3'd3) || (bus.op == 3'd4);
    assign accept   = (state_q == IDLE) && bus.start && !bus.req
                      && (bus.op >= 3'd1) && (bus.op <= 3'd6);
    assign finish   = (state_q == RUN) && (cnt_q == 4'd1);

    assign aSext = {{32{bus.a[31]}}, bus.a};
    assign bSext = {{32{bus.b[31]}}, bus.b};
    assign aZext = {32'd0, bus.a};
    assign bZext = {32'd0, bus.b};

    // Full arithmetic result for the operation presented this cycle. The
    // divide-by-zero and most-negative/-1 cases are resolved explicitly so the
    // divider never sees an undefined operand pair.
    always_comb begin
        opHi = '0;
        opLo = '0;
        case (bus.op)
            3'd1: {opHi, opLo} = aSext * bSext;
            3'd2: {opHi, opLo} = aZext * bZext;
            3'd3: begin
                if (bus.b == 32'd0) begin
                    opLo = 32'hFFFF_FFFF;
                    opHi = bus.a;
                end else if (bus.a == 32'h8000_0000 && bus.b == 32'hFFFF_FFFF) begin
                    opLo = 32'h8000_0000;
                    opHi = 32'd0;
                end else begin
                    opLo = $unsigned($signed(bus.a) / $signed(bus.b));
                    opHi = $unsigned($signed(bus.a) % $signed(bus.b));
                end
            end
            3'd4: begin
                if (bus.b == 32'd0) begin
                    opLo = 32'hFFFF_FFFF;
                    opHi = bus.a;
                end else begin
                    opLo = bus.a / bus.b;
                    opHi = bus.a % bus.b;
                end
            end
            default: begin
                opHi = '0;
                opLo = '0;
            end
        endcase
    end

    // State, counter and data registers. Reset clears everything at once, so
    // an operation in flight is dropped without touching HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            resHi_q <= '0;
            resLo_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resHi_q <= resHi_d;
            resLo_q <= resLo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. RUN lasts exactly as many cycles as the loaded count;
    // the edge that sees cnt==1 is the commit edge. Requests arriving during
    // RUN (including CP0 req) do not restart or cancel the operation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && isMulDiv) begin
                    state_d = RUN;
                    cnt_d   = isDiv ? DIV_LOAD : MULT_LOAD;
                end
            end
            RUN: begin
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Data path updates. Accept and finish cannot coincide because they
    // belong to different states, so HI/LO have a single writer per edge.
    always_comb begin
        resHi_d = resHi_q;
        resLo_d = resLo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = finish;
        if (accept && isMulDiv) begin
            resHi_d = opHi;
            resLo_d = opLo;
        end
        if (accept && bus.op == 3'd5) begin
            hi_d = bus.a;
        end
        if (accept && bus.op == 3'd6) begin
            lo_d = bus.a;
        end
        if (finish) begin
            hi_d = resHi_q;
            lo_d = resLo_q;
        end
    end

    // Outputs. stall also covers the acceptance cycle of a mult/div so the
    // pipeline holds before busy has had a chance to register.
    always_comb begin
        bus.busy  = (state_q == RUN);
        bus.stall = (state_q == RUN) || (bus.start && isMulDiv && !bus.req);
        bus.done  = done_q;
        bus.hi    = hi_q;
        bus.lo    = lo_q;
    end

endmodule

// File: doc/md_sched.md
MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu; both parameters SHALL be in 1..15.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  operation valid from the EX stage this cycle.
REQ-006 SHALL have port op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-007 SHALL have port req  input  1  exception/interrupt request from CP0; suppresses acceptance this cycle.
REQ-008 SHALL have port a  input  32  rs operand.
REQ-009 SHALL have port b  input  32  rt operand.
REQ-010 SHALL have port busy  output  1  multi-cycle operation in progress (registered).
REQ-011 SHALL have port stall  output  1  combinational: busy OR (start AND op in 1..4 AND NOT req); drives the pipeline E_Busy stall.
REQ-012 SHALL have port done  output  1  one-cycle pulse, high in the cycle after HI/LO commit of a mult/div.
REQ-013 SHALL have port hi  output  32  HI register.
REQ-014 SHALL have port lo  output  32  LO register.

Function
REQ-015 SHALL implement two states: IDLE, RUN; a 4-bit down counter cnt; pending result registers res_hi, res_lo.
REQ-016 Acceptance SHALL occur at an edge where state=IDLE, start=1, req=0, op in 1..6.
REQ-017 Accepted mult/multu SHALL compute a*b (signed/unsigned, 64-bit), store upper 32 in res_hi, lower in res_lo, load cnt=MULT_CYCLES, go RUN.
REQ-018 Accepted div/divu SHALL compute quotient to res_lo, remainder to res_hi (signed: quotient truncates toward zero, remainder sign = dividend sign), load cnt=DIV_CYCLES, go RUN.
REQ-019 Divide by zero SHALL yield res_lo=0xFFFFFFFF, res_hi=a, for both div and divu.
REQ-020 div with a=0x80000000, b=0xFFFFFFFF SHALL yield res_lo=0x80000000, res_hi=0.
REQ-021 busy SHALL be 1 for exactly N cycles (N = loaded cnt), starting the cycle after acceptance.
REQ-022 In RUN, cnt SHALL decrement each edge; at the edge where cnt=1, hi<=res_hi, lo<=res_lo, state<=IDLE, done<=1 for the following cycle.
REQ-023 hi/lo SHALL hold prior values throughout RUN; new values visible the cycle busy is first 0.
REQ-024 mthi/mtlo SHALL write a into hi/lo at the acceptance edge, no busy, no done.
REQ-025 start with req=1 SHALL cause no state, hi, lo or counter change.
REQ-026 start while busy=1 SHALL be ignored (no restart, no hi/lo write).
REQ-027 req asserted during RUN SHALL NOT cancel the operation; it completes and commits.
REQ-028 A new operation SHALL be acceptable in the same cycle done is high (IDLE state).
REQ-029 op 0 or 7 with start=1 SHALL be no-op; stall SHALL be 0 for it.

Reset
REQ-030 reset low SHALL immediately force state=IDLE, cnt=0, busy=0, done=0, hi=0, lo=0, res_hi=0, res_lo=0.
REQ-031 reset asserted mid-RUN SHALL abort with no hi/lo commit; after release the block SHALL accept on the next qualifying edge.

Verification
REQ-032 mult a=0xFFFFFFFE b=3 -> busy cycles 1..5, then hi=0xFFFFFFFF lo=0xFFFFFFFA, done pulse once.
REQ-033 multu a=0xFFFFFFFF b=2 -> hi=0x00000001 lo=0xFFFFFFFE after 5 busy cycles.
REQ-034 div a=-7 b=2 -> after 10 busy cycles lo=0xFFFFFFFD hi=0xFFFFFFFF; divu a=7 b=0 -> lo=0xFFFFFFFF hi=7.
REQ-035 start=1 op=mult req=1 -> stall=0, busy stays 0, hi/lo unchanged; req pulse mid-RUN -> result still commits on schedule.
REQ-036 mtlo a=0x12345678 while IDLE -> lo=0x12345678 next cycle, busy=0; mthi during RUN -> ignored, hi gets mult result only.
REQ-037 reset low at RUN cycle 3 of div -> all outputs 0 at once, no done; back-to-back mult issued in done cycle -> accepted, busy 5 cycles.
